// File: rtl/final_nios2_gen2_0_cpu_debug_mem_arbiter.sv
// rtl/final_nios2_gen2_0_cpu_debug_mem_arbiter.sv - OCI debug RAM arbiter between JTAG command path and CPU debug_mem slave
module final_nios2_gen2_0_cpu_debug_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jtag_addr_load,
    input  logic [ADDR_W-1:0]   jtag_addr,
    input  logic                jtag_wr,
    input  logic                jtag_rd,
    input  logic [DATA_W-1:0]   jtag_wdata,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                jtag_overrun,
    input  logic [ADDR_W-1:0]   av_address,
    input  logic                av_read,
    input  logic                av_write,
    input  logic [DATA_W-1:0]   av_writedata,
    input  logic [DATA_W/8-1:0] av_byteenable,
    output logic [DATA_W-1:0]   av_readdata,
    output logic                av_waitrequest,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_be,
    output logic                ram_we,
    output logic                ram_re,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t              state_q, state_d;
    logic                slot_valid_q, slot_valid_d;
    logic                slot_wr_q, slot_wr_d;
    logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
    logic [DATA_W-1:0]   slot_wdata_q, slot_wdata_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                last_jtag_q, last_jtag_d;
    logic                grant_jtag_q, grant_jtag_d;
    logic                acc_wr_q, acc_wr_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [BE_W-1:0]     ram_be_q, ram_be_d;
    logic                ram_we_q, ram_we_d;
    logic                ram_re_q, ram_re_d;
    logic [DATA_W-1:0]   mon_q, mon_d;
    logic [DATA_W-1:0]   rdata_hold_q, rdata_hold_d;
    logic                waitreq_q, waitreq_d;
    logic                overrun_q, overrun_d;
    logic                cpu_req;

    assign cpu_req = av_read | av_write;

    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_wr_d    = slot_wr_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        ptr_d        = ptr_q;
        last_jtag_d  = last_jtag_q;
        grant_jtag_d = grant_jtag_q;
        acc_wr_d     = acc_wr_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_be_d     = ram_be_q;
        ram_we_d     = 1'b0;
        ram_re_d     = 1'b0;
        mon_d        = mon_q;
        rdata_hold_d = rdata_hold_q;
        waitreq_d    = 1'b1;
        overrun_d    = overrun_q;

        // The slot stays full until the JTAG response, so "full" also covers in-flight.
        if (jtag_wr || jtag_rd) begin
            if (!slot_valid_q) begin
                slot_valid_d = 1'b1;
                slot_wr_d    = jtag_wr;
                slot_addr_d  = ptr_q;
                slot_wdata_d = jtag_wdata;
                ptr_d        = ptr_q + 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (jtag_addr_load) begin
            if (slot_valid_q) begin
                overrun_d = 1'b1;
            end else begin
                ptr_d = jtag_addr;
            end
        end

        case (state_q)
            IDLE: begin
                if (slot_valid_q && (!cpu_req || !last_jtag_q)) begin
                    state_d      = ACC;
                    grant_jtag_d = 1'b1;
                    last_jtag_d  = 1'b1;
                    acc_wr_d     = slot_wr_q;
                    ram_addr_d   = slot_addr_q;
                    ram_wdata_d  = slot_wdata_q;
                    ram_be_d     = '1;
                    ram_we_d     = slot_wr_q;
                    ram_re_d     = !slot_wr_q;
                end else if (cpu_req) begin
                    state_d      = ACC;
                    grant_jtag_d = 1'b0;
                    last_jtag_d  = 1'b0;
                    acc_wr_d     = av_write;
                    ram_addr_d   = av_address;
                    ram_wdata_d  = av_writedata;
                    ram_be_d     = av_byteenable;
                    ram_we_d     = av_write;
                    ram_re_d     = !av_write;
                end
            end
            ACC: begin
                state_d = RESP;
                if (!grant_jtag_q) begin
                    waitreq_d = 1'b0;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (grant_jtag_q) begin
                    slot_valid_d = 1'b0;
                    if (!acc_wr_q) begin
                        mon_d = ram_rdata;
                    end
                end else if (!acc_wr_q) begin
                    rdata_hold_d = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_valid_q <= 1'b0;
            slot_wr_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            ptr_q        <= '0;
            last_jtag_q  <= 1'b0;
            grant_jtag_q <= 1'b0;
            acc_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
            mon_q        <= '0;
            rdata_hold_q <= '0;
            waitreq_q    <= 1'b1;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_wr_q    <= slot_wr_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            ptr_q        <= ptr_d;
            last_jtag_q  <= last_jtag_d;
            grant_jtag_q <= grant_jtag_d;
            acc_wr_q     <= acc_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            ram_we_q     <= ram_we_d;
            ram_re_q     <= ram_re_d;
            mon_q        <= mon_d;
            rdata_hold_q <= rdata_hold_d;
            waitreq_q    <= waitreq_d;
            overrun_q    <= overrun_d;
        end
    end

    // RAM data only arrives in RESP, so the CPU read path bypasses the holding register then.
    assign av_readdata    = (state_q == RESP && !grant_jtag_q && !acc_wr_q) ? ram_rdata : rdata_hold_q;
    assign av_waitrequest = waitreq_q;
    assign MonDReg        = mon_q;
    assign monitor_ready  = !slot_valid_q && !(state_q != IDLE && grant_jtag_q);
    assign jtag_overrun   = overrun_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_be         = ram_be_q;
    assign ram_we         = ram_we_q;
    assign ram_re         = ram_re_q;

endmodule
